// File: rtl/window3x3_stream_gen_pkg.sv
`default_nettype none
// ============================================================================
//  window3x3_stream_gen_pkg
//  Shared constants, FSM state type and width helper for the 3x3 window path.
//  Revision: 1.0
// ============================================================================
package window3x3_stream_gen_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int WIN_SIDE  = 3;
    localparam int WIN_TAPS  = WIN_SIDE * WIN_SIDE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/window3x3_stream_gen_if.sv
`default_nettype none
// ============================================================================
//  window3x3_stream_gen_if
//  Pixel-in / window-out stream bundle with frame control and status.
//  Revision: 1.0
// ============================================================================
interface window3x3_stream_gen_if
    import window3x3_stream_gen_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF
);
    logic                      start;
    logic [PIX_W-1:0]          pix_in;
    logic                      pix_valid;
    logic                      pix_ready;
    logic [WIN_TAPS*PIX_W-1:0] win_out;
    logic                      win_valid;
    logic                      win_ready;
    logic                      busy;
    logic                      complete;

    modport slave (
        input  start, pix_in, pix_valid, win_ready,
        output pix_ready, win_out, win_valid, busy, complete
    );

    modport master (
        output start, pix_in, pix_valid, win_ready,
        input  pix_ready, win_out, win_valid, busy, complete
    );
endinterface
`default_nettype wire

// File: rtl/window3x3_stream_gen_line_buf_2row.sv
`default_nettype none
// ============================================================================
//  line_buf_2row
//  Two-line buffer, async read / sync write; each word packs {line r-2, line r-1}.
//  Revision: 1.0
// ============================================================================
module line_buf_2row #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 64,
    parameter int COL_W = 6
) (
    input  wire logic             clk,
    input  wire logic             we,
    input  wire logic [COL_W-1:0] addr,
    input  wire logic [PIX_W-1:0] wr_pix,
    output logic      [PIX_W-1:0] rd_line1,
    output logic      [PIX_W-1:0] rd_line2
);
    logic [2*PIX_W-1:0] r_mem [IMG_W];
    logic [2*PIX_W-1:0] w_word;

    assign w_word   = r_mem[addr];
    assign rd_line1 = w_word[PIX_W-1:0];
    assign rd_line2 = w_word[2*PIX_W-1:PIX_W];

    // Old line r-1 slides into the r-2 half in the same write.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= {w_word[PIX_W-1:0], wr_pix};
        end
    end
endmodule
`default_nettype wire

// File: rtl/window3x3_stream_gen.sv
`default_nettype none
// ============================================================================
//  window3x3_stream_gen
//  Raster pixel stream in, every full 3x3 neighbourhood out as one flat bus.
//  Revision: 1.0
// ============================================================================
module window3x3_stream_gen
    import window3x3_stream_gen_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    window3x3_stream_gen_if.slave  bus
);
    localparam int COL_W = clog2_min1(IMG_W);
    localparam int ROW_W = clog2_min1(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [COL_W-1:0]          r_col;
    logic [ROW_W-1:0]          r_row;
    logic                      r_last_accepted;
    logic                      r_win_valid;
    logic [PIX_W-1:0]          r_win [WIN_SIDE][WIN_SIDE];
    logic [WIN_TAPS*PIX_W-1:0] w_win_flat;
    logic                      w_pix_ready;
    logic                      w_accept;
    logic                      w_win_taken;
    logic                      w_frame_start;
    logic                      w_busy;
    logic                      w_complete;
    logic [PIX_W-1:0]          w_lb_line1;
    logic [PIX_W-1:0]          w_lb_line2;

    assign w_pix_ready   = (r_state == ST_RUN) & (~r_win_valid | bus.win_ready) & ~r_last_accepted;
    assign w_accept      = bus.pix_valid & w_pix_ready;
    assign w_win_taken   = r_win_valid & bus.win_ready;
    assign w_frame_start = (r_state != ST_RUN) & bus.start;

    line_buf_2row #(
        .PIX_W (PIX_W),
        .IMG_W (IMG_W),
        .COL_W (COL_W)
    ) u_line_buf (
        .clk      (clk),
        .we       (w_accept),
        .addr     (r_col),
        .wr_pix   (bus.pix_in),
        .rd_line1 (w_lb_line1),
        .rd_line2 (w_lb_line2)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_next = ST_RUN;
            ST_RUN: begin
                w_busy = 1'b1;
                if (w_win_taken && r_last_accepted) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_complete = 1'b1;
                if (bus.start) w_state_next = ST_RUN;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Windows whose left column wraps from the previous line are suppressed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col           <= '0;
            r_row           <= '0;
            r_last_accepted <= 1'b0;
            r_win_valid     <= 1'b0;
        end else if (w_frame_start) begin
            r_col           <= '0;
            r_row           <= '0;
            r_last_accepted <= 1'b0;
            r_win_valid     <= 1'b0;
        end else if (w_accept) begin
            r_win_valid <= (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
            if (r_col == COL_LAST) begin
                r_col <= '0;
                if (r_row == ROW_LAST) r_last_accepted <= 1'b1;
                else                   r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end else if (w_win_taken) begin
            r_win_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < WIN_SIDE; r++)
                for (int c = 0; c < WIN_SIDE; c++)
                    r_win[r][c] <= '0;
        end else if (w_accept) begin
            for (int r = 0; r < WIN_SIDE; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= w_lb_line2;
            r_win[1][2] <= w_lb_line1;
            r_win[2][2] <= bus.pix_in;
        end
    end

    always_comb begin
        w_win_flat = '0;
        for (int r = 0; r < WIN_SIDE; r++)
            for (int c = 0; c < WIN_SIDE; c++)
                w_win_flat[PIX_W*(WIN_SIDE*r+c) +: PIX_W] = r_win[r][c];
    end

    assign bus.pix_ready = w_pix_ready;
    assign bus.win_out   = w_win_flat;
    assign bus.win_valid = r_win_valid;
    assign bus.busy      = w_busy;
    assign bus.complete  = w_complete;
endmodule
`default_nettype wire

// File: tb/tb_window3x3_stream_gen.sv
`default_nettype none
// ============================================================================
//  tb_window3x3_stream_gen
//  Directed frames on a 4x4 instance and a random 640x8 frame, checked against a window model.
//  Revision: 1.0
// ============================================================================
module tb_window3x3_stream_gen;
    localparam int AW = 4, AH = 4, APW = 8;
    localparam int BW = 640, BH = 8, BPW = 10;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    window3x3_stream_gen_if #(.PIX_W(APW)) bus_a ();
    window3x3_stream_gen_if #(.PIX_W(BPW)) bus_b ();

    window3x3_stream_gen #(.PIX_W(APW), .IMG_W(AW), .IMG_H(AH)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a));
    window3x3_stream_gen #(.PIX_W(BPW), .IMG_W(BW), .IMG_H(BH)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b));

    int errors = 0;
    int checks = 0;
    int img[];
    logic [89:0] exp_q[$];

    task automatic chk(input string tag, input logic [89:0] obs, input logic [89:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic pv, input int px, input logic wr);
        if (sel == 0) begin
            bus_a.start = st; bus_a.pix_valid = pv; bus_a.pix_in = APW'(px); bus_a.win_ready = wr;
        end else begin
            bus_b.start = st; bus_b.pix_valid = pv; bus_b.pix_in = BPW'(px); bus_b.win_ready = wr;
        end
    endtask

    task automatic sample(input int sel, output logic pr, output logic wv, output logic bz,
                          output logic cp, output logic [89:0] wo);
        if (sel == 0) begin
            pr = bus_a.pix_ready; wv = bus_a.win_valid; bz = bus_a.busy;
            cp = bus_a.complete;  wo = 90'(bus_a.win_out);
        end else begin
            pr = bus_b.pix_ready; wv = bus_b.win_valid; bz = bus_b.busy;
            cp = bus_b.complete;  wo = 90'(bus_b.win_out);
        end
    endtask

    task automatic check_idle_outputs(input int sel, input string tag);
        logic pr, wv, bz, cp;
        logic [89:0] wo;
        sample(sel, pr, wv, bz, cp, wo);
        chk({tag, "_pix_ready"}, 90'(pr), 90'(0));
        chk({tag, "_win_valid"}, 90'(wv), 90'(0));
        chk({tag, "_win_out"},   wo,      90'(0));
        chk({tag, "_busy"},      90'(bz), 90'(0));
        chk({tag, "_complete"},  90'(cp), 90'(0));
    endtask

    task automatic fill_img(input int sel, input bit seq);
        int w = (sel != 0) ? BW : AW;
        int h = (sel != 0) ? BH : AH;
        int pw = (sel != 0) ? BPW : APW;
        img = new[w * h];
        foreach (img[i]) img[i] = seq ? i : int'($urandom_range(0, (1 << pw) - 1));
    endtask

    // Reference: every window whose centre lies strictly inside the frame, raster order.
    task automatic build_expected(input int sel);
        int w = (sel != 0) ? BW : AW;
        int h = (sel != 0) ? BH : AH;
        int pw = (sel != 0) ? BPW : APW;
        logic [89:0] v;
        exp_q.delete();
        for (int r = 1; r < h - 1; r++)
            for (int c = 1; c < w - 1; c++) begin
                v = '0;
                for (int k = 0; k < 9; k++)
                    v = v | (90'(img[(r - 1 + k / 3) * w + (c - 1 + k % 3)]) << (pw * k));
                exp_q.push_back(v);
            end
    endtask

    task automatic run_frame(input int sel, input int vpct, input int rpct, input bit stall_first,
                             input int abort_after, input bit mid_start);
        int w = (sel != 0) ? BW : AW;
        int n = w * ((sel != 0) ? BH : AH);
        int pi = 0, cyc = 0, stall_cnt = 0, nwin = 0;
        logic pr, wv, bz, cp, pv, wr, st, acc, taken;
        logic [89:0] wo, prev_wo;
        bit prev_wv = 0, prev_taken = 0, prev_acc = 0, done = 0, first = 1;

        build_expected(sel);
        prev_wo = '0;
        drive(sel, 1'b1, 1'b0, 0, 1'b0);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 0, 1'b0);
        sample(sel, pr, wv, bz, cp, wo);
        chk("busy_after_start", 90'(bz), 90'(1));
        chk("complete_after_start", 90'(cp), 90'(0));

        while (!done) begin
            sample(sel, pr, wv, bz, cp, wo);
            pv = (pi < n) && ($urandom_range(0, 99) < vpct);
            if (stall_first && nwin == 0 && wv && stall_cnt < 5) begin
                wr = 1'b0;
                stall_cnt++;
            end else begin
                wr = ($urandom_range(0, 99) < rpct);
            end
            st = mid_start && (pi == 5);
            drive(sel, st, pv, (pi < n) ? img[pi] : 0, wr);

            @(negedge clk);
            sample(sel, pr, wv, bz, cp, wo);
            if (prev_wv && !prev_taken) chk("win_out_held", wo, prev_wo);
            if (wv && !wr) chk("pix_ready_stalled", 90'(pr), 90'(0));
            if (wv && (!prev_wv || prev_taken)) begin
                chk("win_after_accept", 90'(prev_acc), 90'(1));
                if (first) begin
                    chk("first_win_latency", 90'(pi), 90'(2 * w + 3));
                    first = 0;
                end
            end
            acc   = pv && pr;
            taken = wv && wr;
            if (taken && exp_q.size() > 0) begin
                chk($sformatf("win%0d", nwin), wo, exp_q.pop_front());
                nwin++;
                if (exp_q.size() == 0) done = 1;
            end
            if (acc) pi++;
            prev_wv = wv; prev_taken = taken; prev_acc = acc; prev_wo = wo;

            if (abort_after > 0 && pi == abort_after) begin
                reset_n = 1'b0;
                #1;
                check_idle_outputs(sel, "abort");
                drive(sel, 1'b0, 1'b0, 0, 1'b0);
                @(posedge clk);
                @(negedge clk);
                reset_n = 1'b1;
                @(posedge clk); #1;
                return;
            end

            @(posedge clk); #1;
            cyc++;
            if (cyc > 40000) begin
                chk("timeout_cycles", 90'(cyc), 90'(40000));
                done = 1;
            end
        end
        drive(sel, 1'b0, 1'b0, 0, 1'b0);
        sample(sel, pr, wv, bz, cp, wo);
        chk("complete_set", 90'(cp), 90'(1));
        chk("busy_clear", 90'(bz), 90'(0));
        chk("pix_ready_in_done", 90'(pr), 90'(0));
        chk("win_valid_in_done", 90'(wv), 90'(0));
        chk("pixels_accepted", 90'(pi), 90'(n));
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 1'b0, 1'b0, 0, 1'b0);
        drive(1, 1'b0, 1'b0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs(0, "reset_a");
        check_idle_outputs(1, "reset_b");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        fill_img(0, 1'b1);
        run_frame(0, 100, 100, 1'b0, -1, 1'b0);
        run_frame(0, 100, 100, 1'b1, -1, 1'b0);
        run_frame(0, 50, 100, 1'b0, -1, 1'b0);
        run_frame(0, 100, 100, 1'b0, 7, 1'b0);
        check_idle_outputs(0, "after_abort");
        run_frame(0, 100, 100, 1'b0, -1, 1'b0);
        run_frame(0, 100, 100, 1'b0, -1, 1'b1);
        fill_img(0, 1'b0);
        run_frame(0, 80, 70, 1'b0, -1, 1'b0);

        fill_img(1, 1'b0);
        run_frame(1, 70, 70, 1'b0, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
